npc_gen: RTL and testbench
==========================

NPC_GEN -- requirements
Module: npc_gen

Interface
REQ-001 Parameter BHT_IDX_W, default 4: predictor index width, giving 2^BHT_IDX_W entries.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: next-PC value driven while reset is asserted.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 pc  input  32  current fetch PC from the PC register.
REQ-006 en  input  1  PC register enable; 0 = stall (bubble).
REQ-007 ex_valid  input  1  one-cycle pulse: branch/jal resolved in EX.
REQ-008 ex_pc  input  32  PC of the resolved instruction.
REQ-009 ex_taken  input  1  actual direction.
REQ-010 ex_target  input  32  actual taken target.
REQ-011 ex_pred_taken  input  1  prediction carried down the pipeline with that instruction.
REQ-012 ex_pred_target  input  32  predicted target carried down the pipeline.
REQ-013 ori_npc  output  32  next PC to the PC register.
REQ-014 pred_taken  output  1  prediction for the current pc.
REQ-015 pred_target  output  32  predicted target for the current pc.
REQ-016 flush  output  1  squash the IF/ID and ID/EX contents.
REQ-017 mispredict_cnt  output  32  saturating count of mispredicts.

Function
REQ-018 Each entry SHALL hold: valid, tag = pc[31:BHT_IDX_W+2], target[31:0] and a 2-bit saturating counter; index = pc[BHT_IDX_W+1:2].
REQ-019 Lookup SHALL be combinational: hit = valid && tag match; pred_taken = hit && counter[1]; pred_target = the entry target when pred_taken is 1, otherwise pc+4.
REQ-020 mispredict SHALL be ex_valid && (ex_taken != ex_pred_taken || (ex_taken && ex_target != ex_pred_target)).
REQ-021 The correct PC SHALL be ex_target if ex_taken is 1, otherwise ex_pc+4; all adds are 32-bit and wrap modulo 2^32 (32'hFFFF_FFFC+4 = 0).
REQ-022 Redirect state machine states: IDLE and PENDING.
REQ-023 IDLE with a mispredict and en=1: ori_npc = the correct PC in the same cycle; flush=1; remain in IDLE.
REQ-024 IDLE with a mispredict and en=0: flush=1; latch the correct PC into redir_pc; go to PENDING.
REQ-025 PENDING: ori_npc = redir_pc; flush=0; return to IDLE on the first edge with en=1.
REQ-026 A new mispredict in PENDING SHALL overwrite redir_pc and assert flush=1.
REQ-027 Without a redirect, ori_npc = pred_target.
REQ-028 Priority: a same-cycle mispredict, then PENDING, then the prediction.
REQ-029 Update on ex_valid, at the index of ex_pc, independent of en.
REQ-030 Update on a hit: the counter saturating-increments if ex_taken is 1 and decrements otherwise (bounds 2'b00..2'b11); target is rewritten with ex_target when ex_taken is 1.
REQ-031 Update on a miss: allocate only if ex_taken is 1 (valid=1, tag, target, counter=2'b10); a not-taken miss leaves the table unchanged.
REQ-032 When update and lookup hit the same index in the same cycle, the lookup SHALL see the pre-update contents.
REQ-033 mispredict_cnt SHALL increment by one per mispredict and hold at 32'hFFFF_FFFF.

Reset
REQ-034 While rstn=0: all valid=0, all counters=2'b01, state=IDLE, redir_pc=0, mispredict_cnt=0; ori_npc=RESET_PC, pred_taken=0, pred_target=RESET_PC, flush=0.
REQ-035 Reset asserted during PENDING SHALL discard the pending redirect; no flush after release.
REQ-036 Deassertion SHALL take effect at the next rising clk edge.

Structure
REQ-037 The shared CPU package SHALL hold RESET_PC, the counter encodings (SNT=00, WNT=01, WT=10, ST=11) and the redirect-state enum.
REQ-038 The predictor table SHALL be one sub-module, bht_table, with a combinational read port and a synchronous write port; redirect logic and the counter remain in npc_gen.

Verification
REQ-039 Reset release, pc=0x100, no ex_valid -> ori_npc=0x104, pred_taken=0.
REQ-040 Three taken resolves for ex_pc=0x100, ex_target=0x40, each with ex_pred_* matching the current prediction -> after the first, pc=0x100 gives pred_taken=1 and ori_npc=0x40; the counter saturates at 11.
REQ-041 Entry at 0x100 is ST; resolve not-taken with ex_pred_taken=1 and en=1 -> flush=1 and ori_npc=0x104 in that cycle; counter becomes 10; mispredict_cnt=1.
REQ-042 Same mispredict with en=0 for 3 cycles -> flush for one cycle, then ori_npc=0x104 held until en=1, then back to IDLE.
REQ-043 pc=0xFFFF_FFFC with no entry -> ori_npc=0x0000_0000.
REQ-044 Update and lookup at index 0 in the same cycle -> old prediction shown; new prediction visible the next cycle.

Source files
------------

// File: rtl/npc_gen_pkg.sv
// ---------------------------------------------------------------------------
// npc_gen_pkg
//   Shared CPU definitions used by the next-PC generator and its predictor
//   table: the default reset PC, the 2-bit branch counter encodings, the
//   redirect state enum and the saturating counter update helper.
// ---------------------------------------------------------------------------
package npc_gen_pkg;

   localparam logic [31:0] CPU_RESET_PC = 32'h0000_0000;

   // 2-bit saturating direction counter; bit 1 is the predicted direction.
   typedef enum logic [1:0] {
      CTR_SNT = 2'b00,
      CTR_WNT = 2'b01,
      CTR_WT  = 2'b10,
      CTR_ST  = 2'b11
   } ctr_e;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PENDING = 1'b1
   } redir_state_e;

   // Move the counter one step toward the resolved direction, clamped at
   // the strong states.
   function automatic ctr_e ctr_update(input ctr_e cur, input logic taken);
      ctr_e nxt;
      nxt = cur;
      if (taken) begin
         if (cur != CTR_ST) nxt = ctr_e'(cur + 2'b01);
      end else begin
         if (cur != CTR_SNT) nxt = ctr_e'(cur - 2'b01);
      end
      return nxt;
   endfunction

endpackage

// File: rtl/npc_gen_bht.sv
// ---------------------------------------------------------------------------
// bht_table
//   Direct-mapped branch history / target table with 2^IDX_W entries.
//   Each entry holds valid, tag, target and a 2-bit saturating counter.
//
//   Ports
//     clk, rstn        clock, asynchronous active-low reset
//     rd_pc            lookup PC (combinational read port)
//     rd_taken         lookup hit and counter predicts taken
//     rd_target        stored target of the indexed entry
//     wr_en            a branch/jal resolved this cycle
//     wr_pc            PC of the resolved instruction
//     wr_taken         resolved direction
//     wr_target        resolved taken target
//
//   Writes land on the rising edge, so a same-cycle lookup of the entry
//   being written still returns the old contents.
// ---------------------------------------------------------------------------
module bht_table
   import npc_gen_pkg::*;
#(
   parameter int IDX_W = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] rd_pc,
   output logic        rd_taken,
   output logic [31:0] rd_target,
   input  logic        wr_en,
   input  logic [31:0] wr_pc,
   input  logic        wr_taken,
   input  logic [31:0] wr_target
);

   localparam int N_ENT = 1 << IDX_W;
   localparam int TAG_W = 32 - IDX_W - 2;

   logic             valid_q  [N_ENT];
   logic [TAG_W-1:0] tag_q    [N_ENT];
   logic [31:0]      target_q [N_ENT];
   ctr_e             ctr_q    [N_ENT];

   logic [IDX_W-1:0] rd_idx;
   logic [TAG_W-1:0] rd_tag;
   logic             rd_hit;

   logic [IDX_W-1:0] wr_idx;
   logic [TAG_W-1:0] wr_tag;
   logic             wr_hit;
   logic             wr_do;
   logic [31:0]      new_target;
   ctr_e             new_ctr;

   // Lookup port
   always_comb begin
      rd_idx    = rd_pc[IDX_W+1:2];
      rd_tag    = rd_pc[31:IDX_W+2];
      rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
      rd_taken  = rd_hit && ctr_q[rd_idx][1];
      rd_target = target_q[rd_idx];
   end

   // Update policy: train on a hit, allocate only on a taken miss.
   always_comb begin
      wr_idx     = wr_pc[IDX_W+1:2];
      wr_tag     = wr_pc[31:IDX_W+2];
      wr_hit     = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
      wr_do      = 1'b0;
      new_target = target_q[wr_idx];
      new_ctr    = ctr_q[wr_idx];
      if (wr_en) begin
         if (wr_hit) begin
            wr_do   = 1'b1;
            new_ctr = ctr_update(ctr_q[wr_idx], wr_taken);
            if (wr_taken) new_target = wr_target;
         end else if (wr_taken) begin
            wr_do      = 1'b1;
            new_target = wr_target;
            new_ctr    = CTR_WT;
         end
      end
   end

   // NOTE: the whole array is reset because valid and counter values must
   //       be known immediately after reset; tag/target are cleared too so
   //       no X ever reaches pred_target.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < N_ENT; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= CTR_WNT;
         end
      end else if (wr_do) begin
         valid_q[wr_idx]  <= 1'b1;
         tag_q[wr_idx]    <= wr_tag;
         target_q[wr_idx] <= new_target;
         ctr_q[wr_idx]    <= new_ctr;
      end
   end

endmodule

// File: rtl/npc_gen.sv
// ---------------------------------------------------------------------------
// npc_gen
//   Next-PC generator: branch prediction for the fetch PC, misprediction
//   detection for branches resolved in EX, and a redirect that survives
//   fetch stalls.
//
//   Ports
//     clk, rstn            clock, asynchronous active-low reset
//     pc                   current fetch PC
//     en                   PC register enable (0 = stall)
//     ex_valid             branch/jal resolved in EX this cycle
//     ex_pc                PC of the resolved instruction
//     ex_taken/ex_target   actual direction and taken target
//     ex_pred_taken/_target prediction carried with that instruction
//     ori_npc              next PC to the PC register
//     pred_taken/_target   prediction for the current pc
//     flush                squash IF/ID and ID/EX
//     mispredict_cnt       saturating mispredict count
// ---------------------------------------------------------------------------
module npc_gen
   import npc_gen_pkg::*;
#(
   parameter int          BHT_IDX_W = 4,
   parameter logic [31:0] RESET_PC  = CPU_RESET_PC
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] pc,
   input  logic        en,
   input  logic        ex_valid,
   input  logic [31:0] ex_pc,
   input  logic        ex_taken,
   input  logic [31:0] ex_target,
   input  logic        ex_pred_taken,
   input  logic [31:0] ex_pred_target,
   output logic [31:0] ori_npc,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   output logic        flush,
   output logic [31:0] mispredict_cnt
);

   redir_state_e state_q, state_d;
   logic [31:0]  redir_pc_q, redir_pc_d;
   logic [31:0]  cnt_q, cnt_d;

   logic         lk_taken;
   logic [31:0]  lk_target;
   logic [31:0]  lk_pred_target;
   logic         mispredict;
   logic [31:0]  correct_pc;

   bht_table #(
      .IDX_W (BHT_IDX_W)
   ) u_bht (
      .clk       (clk),
      .rstn      (rstn),
      .rd_pc     (pc),
      .rd_taken  (lk_taken),
      .rd_target (lk_target),
      .wr_en     (ex_valid),
      .wr_pc     (ex_pc),
      .wr_taken  (ex_taken),
      .wr_target (ex_target)
   );

   always_comb begin
      lk_pred_target = lk_taken ? lk_target : pc + 32'd4;
      // A taken branch with the right direction but wrong target is still
      // a mispredict; a not-taken one never cares about the target.
      mispredict = ex_valid &&
                   ((ex_taken != ex_pred_taken) ||
                    (ex_taken && (ex_target != ex_pred_target)));
      correct_pc = ex_taken ? ex_target : ex_pc + 32'd4;
   end

   // Redirect control and mispredict counter next state.
   always_comb begin
      state_d    = state_q;
      redir_pc_d = redir_pc_q;
      cnt_d      = cnt_q;
      if (mispredict && !en) begin
         // Fetch is stalled: hold the correct PC until the PC register moves.
         state_d    = ST_PENDING;
         redir_pc_d = correct_pc;
      end else if (en) begin
         state_d = ST_IDLE;
      end
      if (mispredict && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
   end

   // Outputs: same-cycle mispredict beats a pending redirect beats the
   // prediction. Reset forces the documented idle values.
   always_comb begin
      ori_npc        = lk_pred_target;
      pred_taken     = lk_taken;
      pred_target    = lk_pred_target;
      flush          = mispredict;
      mispredict_cnt = cnt_q;
      if (!rstn) begin
         ori_npc     = RESET_PC;
         pred_taken  = 1'b0;
         pred_target = RESET_PC;
         flush       = 1'b0;
      end else if (mispredict) begin
         ori_npc = correct_pc;
      end else if (state_q == ST_PENDING) begin
         ori_npc = redir_pc_q;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   //       flop samples the pre-edge values computed above.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         redir_pc_q <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         redir_pc_q <= redir_pc_d;
         cnt_q      <= cnt_d;
      end
   end

endmodule

// File: tb/tb_npc_gen.sv
// ---------------------------------------------------------------------------
// tb_npc_gen
//   Scoreboard bench for npc_gen. Each stimulus step computes the expected
//   outputs from a table/queue reference model and pushes them; a monitor on
//   the falling edge pops and compares against the DUT.
// ---------------------------------------------------------------------------
module tb_npc_gen;

   localparam int          IDX_W  = 4;
   localparam int          N_ENT  = 1 << IDX_W;
   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic        clk;
   logic        rstn;
   logic [31:0] pc;
   logic        en;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_target;
   logic [31:0] ori_npc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        flush;
   logic [31:0] mispredict_cnt;

   npc_gen #(
      .BHT_IDX_W (IDX_W),
      .RESET_PC  (RST_PC)
   ) dut (
      .clk            (clk),
      .rstn           (rstn),
      .pc             (pc),
      .en             (en),
      .ex_valid       (ex_valid),
      .ex_pc          (ex_pc),
      .ex_taken       (ex_taken),
      .ex_target      (ex_target),
      .ex_pred_taken  (ex_pred_taken),
      .ex_pred_target (ex_pred_target),
      .ori_npc        (ori_npc),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .flush          (flush),
      .mispredict_cnt (mispredict_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   typedef struct {
      int          id;
      logic [31:0] ori;
      logic        pt;
      logic [31:0] ptgt;
      logic        fl;
      logic [31:0] cnt;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   step_id = 0;

   task automatic check(input string nm, input int id,
                        input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (step %0d): got %h, expected %h", nm, id, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         check("ori_npc",        mon_e.id, ori_npc,              mon_e.ori);
         check("pred_taken",     mon_e.id, {31'd0, pred_taken},  {31'd0, mon_e.pt});
         check("pred_target",    mon_e.id, pred_target,          mon_e.ptgt);
         check("flush",          mon_e.id, {31'd0, flush},       {31'd0, mon_e.fl});
         check("mispredict_cnt", mon_e.id, mispredict_cnt,       mon_e.cnt);
      end
   end

   // ---------------- reference model ----------------
   // Plain arrays indexed by PC word bits, counter kept as an integer 0..3.
   bit          m_valid [N_ENT];
   logic [31:0] m_tag   [N_ENT];
   logic [31:0] m_tgt   [N_ENT];
   int          m_ctr   [N_ENT];
   bit          m_pend;
   logic [31:0] m_pend_pc;
   logic [31:0] m_cnt;

   function automatic int m_index(input logic [31:0] p);
      return int'((p >> 2) & (N_ENT - 1));
   endfunction

   function automatic logic [31:0] m_tagof(input logic [31:0] p);
      return p >> (IDX_W + 2);
   endfunction

   function automatic void model_predict(input logic [31:0] p,
                                         output bit t, output logic [31:0] tg);
      int i;
      i  = m_index(p);
      t  = m_valid[i] && (m_tag[i] == m_tagof(p)) && (m_ctr[i] >= 2);
      tg = t ? m_tgt[i] : p + 32'd4;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < N_ENT; i++) begin
         m_valid[i] = 1'b0;
         m_tag[i]   = '0;
         m_tgt[i]   = '0;
         m_ctr[i]   = 1;
      end
      m_pend    = 1'b0;
      m_pend_pc = '0;
      m_cnt     = '0;
   endfunction

   // One clock of stimulus: drive, predict, push expectation, advance.
   task automatic step(input bit r, input bit e, input logic [31:0] p,
                       input bit xv, input logic [31:0] xpc, input bit xt,
                       input logic [31:0] xtg, input bit xpt,
                       input logic [31:0] xptg);
      exp_t        ex;
      bit          mp;
      bit          pt;
      logic [31:0] ptg;
      logic [31:0] corr;
      int          i;
      rstn = r; en = e; pc = p; ex_valid = xv; ex_pc = xpc; ex_taken = xt;
      ex_target = xtg; ex_pred_taken = xpt; ex_pred_target = xptg;

      mp   = xv && ((xt != xpt) || (xt && (xtg != xptg)));
      corr = xt ? xtg : xpc + 32'd4;
      model_predict(p, pt, ptg);
      ex.id = step_id;
      if (!r) begin
         ex.ori = RST_PC; ex.pt = 1'b0; ex.ptgt = RST_PC; ex.fl = 1'b0; ex.cnt = '0;
      end else begin
         ex.ori  = mp ? corr : (m_pend ? m_pend_pc : ptg);
         ex.pt   = pt;
         ex.ptgt = ptg;
         ex.fl   = mp;
         ex.cnt  = m_cnt;
      end
      sb.push_back(ex);
      step_id++;

      @(posedge clk);
      if (!r) begin
         model_reset();
      end else begin
         if (mp && !e) begin
            m_pend = 1'b1; m_pend_pc = corr;
         end else if (e) begin
            m_pend = 1'b0;
         end
         if (mp && (m_cnt != 32'hFFFF_FFFF)) m_cnt = m_cnt + 32'd1;
         if (xv) begin
            i = m_index(xpc);
            if (m_valid[i] && (m_tag[i] == m_tagof(xpc))) begin
               if (xt) begin
                  if (m_ctr[i] < 3) m_ctr[i]++;
                  m_tgt[i] = xtg;
               end else if (m_ctr[i] > 0) begin
                  m_ctr[i]--;
               end
            end else if (xt) begin
               m_valid[i] = 1'b1; m_tag[i] = m_tagof(xpc);
               m_tgt[i] = xtg; m_ctr[i] = 2;
            end
         end
      end
      #1;
   endtask

   // Resolve a branch carrying the model's own current prediction for it.
   task automatic resolve(input bit e, input logic [31:0] p,
                          input logic [31:0] xpc, input bit xt,
                          input logic [31:0] xtg);
      bit          t;
      logic [31:0] tg;
      model_predict(xpc, t, tg);
      step(1'b1, e, p, 1'b1, xpc, xt, xtg, t, tg);
   endtask

   task automatic idle(input bit e, input logic [31:0] p);
      step(1'b1, e, p, 1'b0, '0, 1'b0, '0, 1'b0, '0);
   endtask

   logic [31:0] pc_set [8];

   initial begin
      pc_set[0] = 32'h0000_0100; pc_set[1] = 32'h0000_0104;
      pc_set[2] = 32'h0000_0140; pc_set[3] = 32'h0000_0400;
      pc_set[4] = 32'h0000_0000; pc_set[5] = 32'hFFFF_FFFC;
      pc_set[6] = 32'h0000_013C; pc_set[7] = 32'h0000_7FFC;
      model_reset();
      rstn = 1'b0; en = 1'b1; pc = '0; ex_valid = 1'b0; ex_pc = '0;
      ex_taken = 1'b0; ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
      @(posedge clk); #1;

      // Reset values, including with a resolve presented during reset.
      step(1'b0, 1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'h40, 1'b0, '0);
      step(1'b0, 1'b1, 32'h100, 1'b0, '0, 1'b0, '0, 1'b0, '0);

      // Release: plain sequential prediction.
      idle(1'b1, 32'h100);

      // Three taken resolves train 0x100 -> 0x40 up to strongly taken.
      repeat (3) resolve(1'b1, 32'h100, 32'h100, 1'b1, 32'h40);
      idle(1'b1, 32'h100);

      // Not-taken resolve against a taken prediction, fetch running.
      resolve(1'b1, 32'h100, 32'h100, 1'b0, 32'h40);
      idle(1'b1, 32'h100);

      // Same mispredict while stalled: flush once, hold redirect, then release.
      resolve(1'b0, 32'h200, 32'h100, 1'b0, 32'h40);
      idle(1'b0, 32'h200);
      idle(1'b0, 32'h200);
      idle(1'b1, 32'h200);
      idle(1'b1, 32'h300);

      // Wrap of the sequential add.
      idle(1'b1, 32'hFFFF_FFFC);

      // Same-index update and lookup: old view first, new view next cycle.
      resolve(1'b1, 32'h400, 32'h400, 1'b1, 32'h80);
      idle(1'b1, 32'h400);

      // Reset while a redirect is pending drops the redirect.
      resolve(1'b0, 32'h500, 32'h400, 1'b0, 32'h80);
      idle(1'b0, 32'h500);
      step(1'b0, 1'b0, 32'h500, 1'b0, '0, 1'b0, '0, 1'b0, '0);
      idle(1'b1, 32'h500);
      idle(1'b1, 32'h504);

      // Randomized traffic over a small aliasing PC set.
      for (int n = 0; n < 3000; n++) begin
         bit          r, e, xv, xt, xpt;
         logic [31:0] p, xpc, xtg, xptg;
         r    = ($urandom_range(0, 299) != 0);
         e    = ($urandom_range(0, 3) != 0);
         p    = pc_set[$urandom_range(0, 7)];
         xv   = ($urandom_range(0, 2) != 0);
         xpc  = pc_set[$urandom_range(0, 7)];
         xt   = $urandom_range(0, 1) == 1;
         xtg  = ($urandom_range(0, 1) == 1) ? pc_set[$urandom_range(0, 7)]
                                             : ($urandom() & 32'hFFFF_FFFC);
         if ($urandom_range(0, 1) == 1) begin
            model_predict(xpc, xpt, xptg);
         end else begin
            xpt  = $urandom_range(0, 1) == 1;
            xptg = pc_set[$urandom_range(0, 7)];
         end
         step(r, e, p, xv, xpc, xt, xtg, xpt, xptg);
      end

      // Drain: every pushed expectation must have been compared.
      repeat (2) @(posedge clk);
      check("scoreboard_drained", step_id, sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
